// File: rtl/load_exec_queue.sv
// Queued LOAD_V/LOAD_M execution controller: command FIFO feeding a shared load engine,
// with a single-entry backpressured write stage and per-command completion reporting.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops it and latches its fields
// ISSUE  | one-cycle engine start pulse
// STREAM | forwarding engine tiles into the write stage
// DRAIN  | engine finished; waiting for the last tile to leave the write stage
// REPORT | one-cycle done pulse with tag and error flags
module load_exec_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int ADDR_WIDTH = 24,
  parameter int DIM_W      = 10,
  parameter int BUF_ID_W   = 5,
  parameter int TAG_W      = 4,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_opcode,
  input  logic [BUF_ID_W-1:0]    cmd_buf_id,
  input  logic [DIM_W-1:0]       cmd_len_cols,
  input  logic [DIM_W-1:0]       cmd_rows,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   eng_start,
  output logic                   eng_sel,
  output logic [ADDR_WIDTH-1:0]  eng_addr,
  output logic [DIM_W-1:0]       eng_len_cols,
  output logic [DIM_W-1:0]       eng_rows,
  input  logic                   eng_tile_valid,
  input  logic [TILE_WIDTH-1:0]  eng_tile_data,
  output logic                   eng_tile_ready,
  input  logic                   eng_done,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic                   wr_is_mat,
  output logic [BUF_ID_W-1:0]    wr_buf_id,
  output logic [TILE_WIDTH-1:0]  wr_tile,
  output logic [2*DIM_W-1:0]     wr_tile_idx,
  output logic                   done,
  output logic [TAG_W-1:0]       done_tag,
  output logic [1:0]             done_err,
  output logic                   idle
);

  localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
  localparam int CNT_W      = 2 * DIM_W;
  localparam int PTR_W      = $clog2(CMD_DEPTH);
  localparam logic [4:0] OP_LOAD_V = 5'h01;
  localparam logic [4:0] OP_LOAD_M = 5'h02;

  typedef struct packed {
    logic [4:0]            opcode;
    logic [BUF_ID_W-1:0]   buf_id;
    logic [DIM_W-1:0]      len_cols;
    logic [DIM_W-1:0]      rows;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TAG_W-1:0]      tag;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  cmd_t             fifo_mem [CMD_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  cmd_t             head;

  logic             head_op_ok;
  logic [CNT_W-1:0] head_tiles_per_row;
  logic [CNT_W-1:0] head_exp;

  logic             op_ok_q;
  logic [BUF_ID_W-1:0] buf_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tile_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{opcode:   cmd_opcode,
                                       buf_id:   cmd_buf_id,
                                       len_cols: cmd_len_cols,
                                       rows:     cmd_rows,
                                       addr:     cmd_addr,
                                       tag:      cmd_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Matrix rows are tile-aligned, so only the column count needs rounding up.
  assign head_op_ok         = (head.opcode == OP_LOAD_V) || (head.opcode == OP_LOAD_M);
  assign head_tiles_per_row = (CNT_W'(head.len_cols) + CNT_W'(TILE_ELEMS - 1)) /
                              CNT_W'(TILE_ELEMS);
  assign head_exp           = (head.opcode == OP_LOAD_M) ?
                              CNT_W'(head.rows) * head_tiles_per_row :
                              head_tiles_per_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    eng_start      = 1'b0;
    eng_tile_ready = 1'b0;
    done           = 1'b0;
    done_tag       = '0;
    done_err       = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!head_op_ok || head_exp == '0) state_d = S_REPORT;
          else                               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        eng_tile_ready = !wr_valid || wr_ready;
        if (eng_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!wr_valid || wr_ready) state_d = S_REPORT;
      end
      S_REPORT: begin
        done     = 1'b1;
        done_tag = tag_q;
        done_err = {op_ok_q && (cnt_q != exp_q), !op_ok_q};
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tile_acc = eng_tile_valid && eng_tile_ready;
  assign idle     = fifo_empty && (state_q == S_IDLE) && !wr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ok_q      <= 1'b0;
      buf_q        <= '0;
      tag_q        <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      eng_sel      <= 1'b0;
      eng_addr     <= '0;
      eng_len_cols <= '0;
      eng_rows     <= '0;
    end else if (pop) begin
      op_ok_q      <= head_op_ok;
      buf_q        <= head.buf_id;
      tag_q        <= head.tag;
      exp_q        <= head_exp;
      cnt_q        <= '0;
      eng_sel      <= (head.opcode == OP_LOAD_M);
      eng_addr     <= head.addr;
      eng_len_cols <= head.len_cols;
      eng_rows     <= head.rows;
    end else if (tile_acc && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Single-entry write stage; a new tile may replace the old one in the same cycle it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid    <= 1'b0;
      wr_is_mat   <= 1'b0;
      wr_buf_id   <= '0;
      wr_tile     <= '0;
      wr_tile_idx <= '0;
    end else if (tile_acc) begin
      wr_valid    <= 1'b1;
      wr_is_mat   <= eng_sel;
      wr_buf_id   <= buf_q;
      wr_tile     <= eng_tile_data;
      wr_tile_idx <= cnt_q;
    end else if (wr_ready) begin
      wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_exec_queue.sv
// Directed bench for load_exec_queue: table of single-command vectors plus
// hand-written sequences for backpressure, FIFO full and mid-stream reset.
module tb_load_exec_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [4:0]   cmd_opcode;
  logic [4:0]   cmd_buf_id;
  logic [9:0]   cmd_len_cols, cmd_rows;
  logic [23:0]  cmd_addr;
  logic [3:0]   cmd_tag;
  logic         eng_start, eng_sel;
  logic [23:0]  eng_addr;
  logic [9:0]   eng_len_cols, eng_rows;
  logic         eng_tile_valid;
  logic [255:0] eng_tile_data;
  logic         eng_tile_ready, eng_done;
  logic         wr_valid, wr_ready, wr_is_mat;
  logic [4:0]   wr_buf_id;
  logic [255:0] wr_tile;
  logic [19:0]  wr_tile_idx;
  logic         done;
  logic [3:0]   done_tag;
  logic [1:0]   done_err;
  logic         idle;

  load_exec_queue dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_buf_id(cmd_buf_id), .cmd_len_cols(cmd_len_cols), .cmd_rows(cmd_rows),
    .cmd_addr(cmd_addr), .cmd_tag(cmd_tag),
    .eng_start(eng_start), .eng_sel(eng_sel), .eng_addr(eng_addr),
    .eng_len_cols(eng_len_cols), .eng_rows(eng_rows),
    .eng_tile_valid(eng_tile_valid), .eng_tile_data(eng_tile_data),
    .eng_tile_ready(eng_tile_ready), .eng_done(eng_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_is_mat(wr_is_mat),
    .wr_buf_id(wr_buf_id), .wr_tile(wr_tile), .wr_tile_idx(wr_tile_idx),
    .done(done), .done_tag(done_tag), .done_err(done_err), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [9:0] len;
    logic [9:0] rows;
    logic [3:0] tag;
    int         n_tiles;
    bit         done_on_last;
    bit         exp_start;
    logic [1:0] exp_err;
  } vec_t;

  typedef struct {
    logic [19:0]  idx;
    logic [255:0] tile;
    logic         is_mat;
    logic [4:0]   buf_id;
    int           cyc;
  } wr_rec_t;

  typedef struct {
    logic [3:0] tag;
    logic [1:0] err;
    int         cyc;
  } done_rec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int push_cyc, edone_cyc;
  int start_cnt = 0, start_cyc = 0;
  logic        start_sel;
  logic [9:0]  start_len;
  logic [23:0] start_addr;
  int stall_err = 0, hold_err = 0;
  bit prev_stall = 0;
  logic [255:0] prev_tile;
  logic [19:0]  prev_idx;
  bit stop_tog;
  wr_rec_t   wr_q[$];
  done_rec_t done_q[$];
  vec_t      vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] pat(input logic [3:0] tag, input int i);
    logic [31:0] w;
    logic [15:0] lo;
    lo = i[15:0];
    w = {8'hC3, 4'h0, tag, lo};
    return {8{w}};
  endfunction

  function automatic logic [23:0] addr_of(input logic [3:0] tag);
    return {4'h5, tag, 16'hBEEF};
  endfunction

  function automatic vec_t mk(input logic [4:0] op, input logic [9:0] len, input logic [9:0] rows,
                              input logic [3:0] tag, input int n, input bit dol, input bit st,
                              input logic [1:0] err);
    vec_t v;
    v.op = op; v.len = len; v.rows = rows; v.tag = tag; v.n_tiles = n;
    v.done_on_last = dol; v.exp_start = st; v.exp_err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Observer: samples mid-cycle, well clear of the rising edge.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (eng_start) begin
        start_cnt++;
        start_cyc  = cyc;
        start_sel  = eng_sel;
        start_len  = eng_len_cols;
        start_addr = eng_addr;
      end
      if (wr_valid && wr_ready) begin
        wr_rec_t r;
        r.idx = wr_tile_idx; r.tile = wr_tile; r.is_mat = wr_is_mat;
        r.buf_id = wr_buf_id; r.cyc = cyc;
        wr_q.push_back(r);
      end
      if (done) begin
        done_rec_t d;
        d.tag = done_tag; d.err = done_err; d.cyc = cyc;
        done_q.push_back(d);
      end
      if (eng_tile_ready && wr_valid && !wr_ready) stall_err++;
      if (prev_stall && !(wr_valid && wr_tile == prev_tile && wr_tile_idx == prev_idx)) hold_err++;
      prev_stall = wr_valid && !wr_ready;
      prev_tile  = wr_tile;
      prev_idx   = wr_tile_idx;
    end
  end

  task automatic clear_logs();
    start_cnt = 0;
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic push(input logic [4:0] op, input logic [9:0] lc, input logic [9:0] rows,
                      input logic [3:0] tag);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_len_cols = lc; cmd_rows = rows;
    cmd_tag = tag; cmd_addr = addr_of(tag); cmd_buf_id = {1'b0, tag} + 5'd3;
    #1;
    while (!cmd_ready && w < 50) begin @(negedge clk); #1; w++; end
    if (!cmd_ready) fail_timeout("push_ready");
    push_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_tile(input logic [255:0] d, input bit with_done);
    int w;
    w = 0;
    eng_tile_valid = 1'b1;
    eng_tile_data  = d;
    #1;
    while (!eng_tile_ready && w < 50) begin @(negedge clk); #1; w++; end
    if (!eng_tile_ready) fail_timeout("tile_ready");
    eng_done = with_done;
    if (with_done) edone_cyc = cyc;
    @(negedge clk);
    eng_tile_valid = 1'b0;
    eng_done = 1'b0;
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    edone_cyc = cyc;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  task automatic wait_starts(input int n, input string name);
    int w;
    w = 0;
    while (start_cnt < n && w < 30) begin @(negedge clk); w++; end
    if (start_cnt < n) fail_timeout(name);
  endtask

  task automatic wait_dones(input int n, input string name);
    int w;
    w = 0;
    while (done_q.size() < n && w < 200) begin @(negedge clk); w++; end
    if (done_q.size() < n) fail_timeout(name);
  endtask

  task automatic check_rst(input string p);
    check({p, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({p, "_idle"}, 64'(idle), 64'd1);
    check({p, "_eng"}, 64'({eng_start, eng_sel, eng_tile_ready, |eng_addr, |eng_len_cols, |eng_rows}), 64'd0);
    check({p, "_wr"}, 64'({wr_valid, wr_is_mat, |wr_buf_id, |wr_tile, |wr_tile_idx}), 64'd0);
    check({p, "_done"}, 64'({done, done_tag, done_err}), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    clear_logs();
    push(v.op, v.len, v.rows, v.tag);
    if (v.exp_start) begin
      wait_starts(1, $sformatf("v%0d_start", k));
      check($sformatf("v%0d_start_lat", k), 64'(start_cyc - push_cyc), 64'd2);
      check($sformatf("v%0d_eng_sel", k), 64'(start_sel), 64'(v.op == 5'h02));
      check($sformatf("v%0d_eng_len", k), 64'(start_len), 64'(v.len));
      check($sformatf("v%0d_eng_addr", k), 64'(start_addr), 64'(addr_of(v.tag)));
      for (int i = 0; i < v.n_tiles; i++)
        send_tile(pat(v.tag, i), v.done_on_last && (i == v.n_tiles - 1));
      if (!v.done_on_last) pulse_done();
    end
    wait_dones(1, $sformatf("v%0d_done", k));
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_n_start", k), 64'(start_cnt), 64'(v.exp_start));
    check($sformatf("v%0d_n_done", k), 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) begin
      check($sformatf("v%0d_tag", k), 64'(done_q[0].tag), 64'(v.tag));
      check($sformatf("v%0d_err", k), 64'(done_q[0].err), 64'(v.exp_err));
      if (v.exp_start)
        check($sformatf("v%0d_done_lat", k), 64'(done_q[0].cyc - edone_cyc), 64'd2);
      else
        check($sformatf("v%0d_done_lat", k), 64'(done_q[0].cyc - push_cyc), 64'd2);
    end
    check($sformatf("v%0d_n_wr", k), 64'(wr_q.size()), 64'(v.n_tiles));
    for (int i = 0; i < wr_q.size(); i++) begin
      check($sformatf("v%0d_wr%0d_idx", k, i), 64'(wr_q[i].idx), 64'(i));
      check($sformatf("v%0d_wr%0d_tile", k, i), 64'(wr_q[i].tile == pat(v.tag, i)), 64'd1);
      check($sformatf("v%0d_wr%0d_mat", k, i), 64'(wr_q[i].is_mat), 64'(v.op == 5'h02));
      check($sformatf("v%0d_wr%0d_buf", k, i), 64'(wr_q[i].buf_id), 64'({1'b0, v.tag} + 5'd3));
      if (i > 0)
        check($sformatf("v%0d_wr%0d_b2b", k, i), 64'(wr_q[i].cyc - wr_q[i-1].cyc), 64'd1);
    end
    check($sformatf("v%0d_idle", k), 64'(idle), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // op, len/cols, rows, tag, tiles sent, done with last tile, expect start, expect err
    vecs[0]  = mk(5'h01, 10'd70, 10'd0, 4'd1,  3, 0, 1, 2'b00);
    vecs[1]  = mk(5'h01, 10'd64, 10'd0, 4'd2,  1, 0, 1, 2'b10);
    vecs[2]  = mk(5'h01, 10'd64, 10'd0, 4'd3,  2, 1, 1, 2'b00);
    vecs[3]  = mk(5'h07, 10'd5,  10'd0, 4'd9,  0, 0, 0, 2'b01);
    vecs[4]  = mk(5'h01, 10'd0,  10'd0, 4'd4,  0, 0, 0, 2'b00);
    vecs[5]  = mk(5'h02, 10'd32, 10'd2, 4'd5,  2, 1, 1, 2'b00);
    vecs[6]  = mk(5'h02, 10'd0,  10'd3, 4'd6,  0, 0, 0, 2'b00);
    vecs[7]  = mk(5'h01, 10'd32, 10'd0, 4'd7,  2, 0, 1, 2'b10);
    vecs[8]  = mk(5'h01, 10'd1,  10'd0, 4'd8,  1, 1, 1, 2'b00);
    vecs[9]  = mk(5'h00, 10'd40, 10'd1, 4'd10, 0, 0, 0, 2'b01);
    vecs[10] = mk(5'h02, 10'd33, 10'd1, 4'd12, 1, 1, 1, 2'b10);
    vecs[11] = mk(5'h03, 10'd0,  10'd0, 4'd13, 0, 0, 0, 2'b01);

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_buf_id = '0; cmd_len_cols = '0;
    cmd_rows = '0; cmd_addr = '0; cmd_tag = '0;
    eng_tile_valid = 1'b0; eng_tile_data = '0; eng_done = 1'b0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_rst("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 12; k++) run_vec(vecs[k], k);

    // LOAD_M 4x40 -> 8 tiles under alternating write-side backpressure.
    clear_logs();
    stall_err = 0; hold_err = 0; stop_tog = 0;
    push(5'h02, 10'd40, 10'd4, 4'd14);
    wait_starts(1, "bp_start");
    fork
      begin
        while (!stop_tog) begin @(negedge clk); wr_ready = ~wr_ready; end
      end
      begin
        for (int i = 0; i < 8; i++) send_tile(pat(4'd14, i), 1'b0);
        pulse_done();
        wait_dones(1, "bp_done");
        stop_tog = 1;
      end
    join
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_n_wr", 64'(wr_q.size()), 64'd8);
    for (int i = 0; i < wr_q.size(); i++) begin
      check($sformatf("bp_wr%0d_idx", i), 64'(wr_q[i].idx), 64'(i));
      check($sformatf("bp_wr%0d_tile", i), 64'(wr_q[i].tile == pat(4'd14, i)), 64'd1);
    end
    check("bp_stall_ready", 64'(stall_err), 64'd0);
    check("bp_hold", 64'(hold_err), 64'd0);
    check("bp_n_done", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) begin
      check("bp_tag", 64'(done_q[0].tag), 64'd14);
      check("bp_err", 64'(done_q[0].err), 64'd0);
    end

    // Fill the FIFO behind a busy command, then drain in order.
    clear_logs();
    push(5'h01, 10'd32, 10'd0, 4'd0);
    wait_starts(1, "ff_start0");
    for (int t = 1; t <= 4; t++) push(5'h01, 10'd32, 10'd0, 4'(t));
    cmd_valid = 1'b1; cmd_opcode = 5'h01; cmd_len_cols = 10'd32; cmd_tag = 4'd5;
    #1;
    check("ff_full_ready", 64'(cmd_ready), 64'd0);
    check("ff_idle_busy", 64'(idle), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_starts(k + 1, $sformatf("ff_start%0d", k));
      send_tile(pat(4'(k), 0), 1'b1);
    end
    wait_dones(5, "ff_done");
    repeat (5) @(negedge clk);
    check("ff_n_done", 64'(done_q.size()), 64'd5);
    check("ff_n_start", 64'(start_cnt), 64'd5);
    for (int i = 0; i < done_q.size(); i++) begin
      check($sformatf("ff_done%0d_tag", i), 64'(done_q[i].tag), 64'(i));
      check($sformatf("ff_done%0d_err", i), 64'(done_q[i].err), 64'd0);
    end
    check("ff_ready_after", 64'(cmd_ready), 64'd1);

    // Reset while streaming with two commands queued.
    clear_logs();
    push(5'h01, 10'd96, 10'd0, 4'd11);
    wait_starts(1, "rst_start");
    send_tile(pat(4'd11, 0), 1'b0);
    push(5'h01, 10'd32, 10'd0, 4'd12);
    push(5'h02, 10'd32, 10'd2, 4'd13);
    check("rst_pre_busy", 64'(idle), 64'd0);
    rst = 1'b1;
    #1;
    check_rst("midrst");
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    check("rst_no_done", 64'(done_q.size()), 64'd0);
    check("rst_no_start", 64'(start_cnt), 64'd0);
    #1;
    check_rst("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
